// File: rtl/btn_conditioner.sv
// Button/switch input conditioner: 2-flop synchroniser, counter debounce,
// clean level plus registered press/release pulses with optional hold-to-repeat.
module btn_conditioner #(
  parameter int              N_IN            = 5,
  parameter int              DEBOUNCE_CYCLES = 400000,
  parameter int              REPEAT_DELAY    = 16000000,
  parameter int              REPEAT_PERIOD   = 4000000,
  parameter logic [N_IN-1:0] REPEAT_MASK     = 5'b01111
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [N_IN-1:0] raw_i,
  output logic [N_IN-1:0] level_o,
  output logic [N_IN-1:0] press_o,
  output logic [N_IN-1:0] release_o
);

  localparam int DW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RW = $clog2(REPEAT_DELAY + 1);

  localparam logic [DW-1:0] DEB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] RPT_FIRE   = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [N_IN-1:0] s1_q, s2_q;
  logic [N_IN-1:0] level_q, press_q, release_q;
  logic [N_IN-1:0] level_d, press_d, release_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_chan
      localparam bit RPT_EN = REPEAT_MASK[gi];

      logic [DW-1:0] dcnt_q, dcnt_d;
      logic [RW-1:0] rcnt_q, rcnt_d;
      logic          accept;
      logic          lvl_d, prs_d, rel_d;

      assign accept = (s2_q[gi] != level_q[gi]) && (dcnt_q == DEB_MAX);

      always_comb begin
        dcnt_d = dcnt_q;
        rcnt_d = rcnt_q;
        lvl_d  = level_q[gi];
        prs_d  = 1'b0;
        rel_d  = 1'b0;

        if (s2_q[gi] == level_q[gi]) begin
          dcnt_d = '0;
        end else if (dcnt_q == DEB_MAX) begin
          dcnt_d = '0;
          lvl_d  = s2_q[gi];
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end

        // An accepted release beats a repeat that falls due on the same edge.
        if (accept && s2_q[gi]) begin
          prs_d  = 1'b1;
          rcnt_d = '0;
        end else if (accept && !s2_q[gi]) begin
          rel_d  = 1'b1;
          rcnt_d = '0;
        end else if (RPT_EN && level_q[gi]) begin
          if (rcnt_q == RPT_FIRE) begin
            prs_d  = 1'b1;
            rcnt_d = RPT_RELOAD;
          end else begin
            rcnt_d = rcnt_q + 1'b1;
          end
        end

        if (!RPT_EN) begin
          rcnt_d = '0;
        end
      end

      always_ff @(posedge clk) begin
        if (clr) begin
          dcnt_q <= '0;
          rcnt_q <= '0;
        end else begin
          dcnt_q <= dcnt_d;
          rcnt_q <= rcnt_d;
        end
      end

      assign level_d[gi]   = lvl_d;
      assign press_d[gi]   = prs_d;
      assign release_d[gi] = rel_d;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr) begin
      s1_q      <= '0;
      s2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      s1_q      <= raw_i;
      s2_q      <= s1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short debounce/repeat timings;
// En denotes the n-th rising edge after raw_i is driven.
module tb_btn_conditioner;

  logic       clk;
  logic       clr;
  logic [4:0] raw_i;
  logic [4:0] level_o, press_o, release_o;

  int tests_run    = 0;
  int tests_failed = 0;

  btn_conditioner #(
    .N_IN           (5),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (5),
    .REPEAT_MASK    (5'b01111)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .raw_i    (raw_i),
    .level_o  (level_o),
    .press_o  (press_o),
    .release_o(release_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int n,
                            input logic [4:0] el, input logic [4:0] ep, input logic [4:0] er);
    check_eq($sformatf("%s_lvl_e%0d", tag, n), {27'd0, level_o},   {27'd0, el});
    check_eq($sformatf("%s_prs_e%0d", tag, n), {27'd0, press_o},   {27'd0, ep});
    check_eq($sformatf("%s_rel_e%0d", tag, n), {27'd0, release_o}, {27'd0, er});
  endtask

  task automatic do_reset();
    raw_i = 5'b0;
    clr   = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    tick();
  endtask

  initial begin
    clr   = 1'b1;
    raw_i = 5'b11111;
    tick(); tick(); tick();
    check_outs("reset", 0, 5'b0, 5'b0, 5'b0);
    $display("[TB] reset held with raw high");

    // Clean press on bit 0.
    do_reset();
    raw_i = 5'b00001;
    for (int n = 0; n <= 8; n++) begin
      tick();
      check_outs("clean", n, (n >= 5) ? 5'b00001 : 5'b0, (n == 5) ? 5'b00001 : 5'b0, 5'b0);
    end
    $display("[TB] clean press on bit 0");

    // Glitch of 3 cycles on bit 1 is rejected.
    do_reset();
    raw_i = 5'b00010;
    for (int n = 0; n <= 12; n++) begin
      tick();
      check_outs("glitch3", n, 5'b0, 5'b0, 5'b0);
      if (n == 2) raw_i = 5'b0;
    end
    $display("[TB] 3-cycle glitch on bit 1");

    // 4 cycles high is accepted; release 4 cycles after s2 falls.
    do_reset();
    raw_i = 5'b00010;
    for (int n = 0; n <= 14; n++) begin
      tick();
      check_outs("glitch4", n, (n >= 5 && n <= 8) ? 5'b00010 : 5'b0,
                 (n == 5) ? 5'b00010 : 5'b0, (n == 9) ? 5'b00010 : 5'b0);
      if (n == 3) raw_i = 5'b0;
    end
    $display("[TB] 4-cycle pulse on bit 1");

    // Bounce 1,1,0,1,... on bit 2 restarts the count.
    do_reset();
    raw_i = 5'b00100;
    for (int n = 0; n <= 12; n++) begin
      tick();
      check_outs("bounce", n, (n >= 8) ? 5'b00100 : 5'b0, (n == 8) ? 5'b00100 : 5'b0, 5'b0);
      if (n == 1) raw_i = 5'b0;
      if (n == 2) raw_i = 5'b00100;
    end
    $display("[TB] bounce on bit 2");

    // Auto-repeat on bit 3; release lands on the edge a repeat is due (E25).
    do_reset();
    raw_i = 5'b01000;
    for (int n = 0; n <= 40; n++) begin
      tick();
      check_outs("repeat", n, (n >= 5 && n <= 24) ? 5'b01000 : 5'b0,
                 (n == 5 || n == 15 || n == 20) ? 5'b01000 : 5'b0,
                 (n == 25) ? 5'b01000 : 5'b0);
      if (n == 19) raw_i = 5'b0;
    end
    $display("[TB] auto-repeat on bit 3");

    // Rotate channel never repeats.
    do_reset();
    raw_i = 5'b10000;
    for (int n = 0; n <= 100; n++) begin
      tick();
      check_outs("norpt", n, (n >= 5) ? 5'b10000 : 5'b0, (n == 5) ? 5'b10000 : 5'b0, 5'b0);
    end
    $display("[TB] held rotate on bit 4");

    // Reset mid-operation with raw held high.
    do_reset();
    raw_i = 5'b00001;
    for (int n = 0; n <= 16; n++) begin
      tick();
      check_outs("midrst", n, ((n >= 5 && n <= 7) || n >= 14) ? 5'b00001 : 5'b0,
                 (n == 5 || n == 14) ? 5'b00001 : 5'b0, 5'b0);
      if (n == 7) clr = 1'b1;
      if (n == 8) clr = 1'b0;
    end
    $display("[TB] reset mid-operation on bit 0");

    // All channels pressed and released together.
    do_reset();
    raw_i = 5'b11111;
    for (int n = 0; n <= 16; n++) begin
      tick();
      check_outs("all", n, (n >= 5 && n <= 11) ? 5'b11111 : 5'b0,
                 (n == 5) ? 5'b11111 : 5'b0, (n == 12) ? 5'b11111 : 5'b0);
      if (n == 6) raw_i = 5'b0;
    end
    $display("[TB] simultaneous channels");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
